// File: rtl/instr_decode_queue.sv
// instr_decode_queue: prefetch FIFO (in_valid/in_ready push, ir_write pop) feeding an IR with MIPS R/I/J field decode, immediate extension, flush and underflow pulse
module instr_decode_queue #(
  parameter int IW    = 32,
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CW    = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [IW-1:0]   in_ins,
  output logic            in_ready,
  input  logic            ir_write,
  input  logic            flush,
  output logic            ir_valid,
  output logic            underflow,
  output logic [5:0]      opcode,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [4:0]      shamt,
  output logic [5:0]      funct,
  output logic [15:0]     imm,
  output logic [XLEN-1:0] imm_ext,
  output logic [25:0]     jtarget,
  output logic [1:0]      fmt,
  output logic [CW-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ir_q;
  logic          ir_valid_q, uf_q, push, pop, empty;
  assign empty    = cnt_q == '0;
  assign in_ready = cnt_q < CW'(DEPTH);
  assign push     = in_valid && in_ready;
  assign pop      = ir_write && !empty;
  assign cnt_d    = cnt_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wr_q] <= in_ins[31:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      uf_q       <= 1'b0;
    end else if (flush) begin
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      wr_q       <= push ? wr_q + AW'(1) : wr_q;
      rd_q       <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q      <= cnt_d;
      ir_q       <= pop ? mem_q[rd_q] : ir_q;
      ir_valid_q <= ir_write ? !empty : ir_valid_q;
      uf_q       <= ir_write && empty;
    end
  assign ir_valid  = ir_valid_q;
  assign underflow = uf_q;
  assign count     = cnt_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign shamt     = ir_q[10:6];
  assign funct     = ir_q[5:0];
  assign imm       = ir_q[15:0];
  assign jtarget   = ir_q[25:0];
  always_comb begin
    fmt     = opcode == 6'h00 ? 2'd0 : (opcode == 6'h02 || opcode == 6'h03) ? 2'd2 : 2'd1;
    imm_ext = (opcode inside {6'h0C, 6'h0D, 6'h0E}) ? XLEN'(imm) : XLEN'($signed(imm));
  end
endmodule

// File: tb/tb_instr_decode_queue.sv
// tb_instr_decode_queue: directed self-checking bench for instr_decode_queue
module tb_instr_decode_queue;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, ir_write = 1'b0, flush = 1'b0;
  logic [31:0] in_ins = '0;
  logic        in_ready, ir_valid, underflow;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_ext;
  logic [25:0] jtarget;
  logic [1:0]  fmt;
  logic [2:0]  count;
  int errors = 0, checks = 0;
  instr_decode_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ins(in_ins), .in_ready(in_ready),
    .ir_write(ir_write), .flush(flush), .ir_valid(ir_valid), .underflow(underflow),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .imm_ext(imm_ext), .jtarget(jtarget), .fmt(fmt), .count(count)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_irv", ir_valid, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_op", opcode, 0);
    chk("rst_fmt", fmt, 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_ins = i;
      cyc();
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    in_ins = 32'hDEADBEEF;
    cyc();
    chk("full_ignore_count", count, 4);
    in_valid = 1'b0;
    ir_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("pop_order", imm, i);
      chk("pop_irv", ir_valid, 1);
    end
    chk("drain_count", count, 0);
    in_valid = 1'b1;
    in_ins = 32'h08000010;
    cyc();
    chk("uf_pulse", underflow, 1);
    chk("uf_irv", ir_valid, 0);
    chk("uf_ir_hold", imm, 4);
    chk("uf_push_count", count, 1);
    in_valid = 1'b0;
    ir_write = 1'b0;
    cyc();
    chk("uf_one_cycle", underflow, 0);
    chk("uf_ir_still", imm, 4);
    ir_write = 1'b1;
    cyc();
    chk("j_fmt", fmt, 2);
    chk("j_target", jtarget, 32'h10);
    chk("j_irv", ir_valid, 1);
    ir_write = 1'b0;
    in_valid = 1'b1;
    in_ins = 32'h012A4020;
    cyc();
    in_ins = 32'h3508FFFF;
    cyc();
    in_ins = 32'h2108FFFF;
    cyc();
    in_ins = 32'h0C000040;
    cyc();
    in_valid = 1'b0;
    ir_write = 1'b1;
    cyc();
    chk("r_fmt", fmt, 0);
    chk("r_rs", rs, 9);
    chk("r_rt", rt, 10);
    chk("r_rd", rd, 8);
    chk("r_shamt", shamt, 0);
    chk("r_funct", funct, 32'h20);
    cyc();
    chk("ori_fmt", fmt, 1);
    chk("ori_op", opcode, 32'h0D);
    chk("ori_ext", imm_ext, 32'h0000FFFF);
    cyc();
    chk("addi_fmt", fmt, 1);
    chk("addi_ext", imm_ext, 32'hFFFFFFFF);
    cyc();
    chk("jal_fmt", fmt, 2);
    chk("jal_target", jtarget, 32'h40);
    chk("dec_count", count, 0);
    ir_write = 1'b0;
    in_valid = 1'b1;
    in_ins = 32'hA0;
    cyc();
    in_ins = 32'hA1;
    cyc();
    chk("wrap_pre_count", count, 2);
    ir_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_ins = 32'hA2 + i;
      cyc();
      chk("wrap_order", imm, 32'hA0 + i);
      chk("wrap_count", count, 2);
    end
    ir_write = 1'b0;
    in_ins = 32'hAC;
    cyc();
    chk("fl_pre_count", count, 3);
    chk("fl_pre_irv", ir_valid, 1);
    flush = 1'b1;
    ir_write = 1'b1;
    in_ins = 32'h000000FF;
    cyc();
    chk("fl_count", count, 0);
    chk("fl_irv", ir_valid, 0);
    chk("fl_ir", imm, 0);
    chk("fl_uf", underflow, 0);
    flush = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk("fl_dropped", underflow, 1);
    chk("fl_dropped_count", count, 0);
    ir_write = 1'b0;
    in_valid = 1'b1;
    in_ins = 32'h8C0000B1;
    cyc();
    in_ins = 32'h8C0000B2;
    cyc();
    in_ins = 32'h8C0000B3;
    cyc();
    ir_write = 1'b1;
    in_ins = 32'h8C0000B4;
    cyc();
    in_valid = 1'b0;
    ir_write = 1'b0;
    chk("mr_pre_count", count, 3);
    chk("mr_pre_irv", ir_valid, 1);
    chk("mr_pre_op", opcode, 32'h23);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_count", count, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_irv", ir_valid, 0);
    chk("mr_op", opcode, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    chk("post_rst_count", count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_decode_queue.md
Name: instr_decode_queue

Overview:
- Parametrised successor to the multicycle CPU's instruction-field latch.
- Adds a DEPTH-entry prefetch FIFO with a valid/ready push handshake in front of the instruction register (IR).
- Adds full R/I/J field decode, format classification, extended immediate, jump target, flush and underflow reporting.
- Sits between instruction memory fetch and the control FSM/register file. The control FSM pops with ir_write.

Parameters:
- IW, 32: instruction width in bits; must be ≥32. Field positions follow MIPS bits [31:0]; bits above 31 are ignored.
- DEPTH, 4: FIFO entries; power of 2, ≥2.
- XLEN, 32: width of the extended immediate.
- CW, 3: count width; must equal log2(DEPTH)+1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  fetch word present on in_ins.
- in_ins  in  IW  fetched instruction.
- in_ready  out  1  FIFO can accept; equals (count < DEPTH).
- ir_write  in  1  pop FIFO head into IR.
- flush  in  1  discard FIFO contents and invalidate IR.
- ir_valid  out  1  IR holds a live instruction.
- underflow  out  1  one-cycle pulse: ir_write while FIFO empty.
- opcode  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- shamt  out  5  IR[10:6].
- funct  out  6  IR[5:0].
- imm  out  16  IR[15:0].
- imm_ext  out  XLEN  extended imm.
- jtarget  out  26  IR[25:0].
- fmt  out  2  0=R, 1=I, 2=J, 3=never driven.
- count  out  CW  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (async, immediate) clears all state:
  - FIFO rd/wr pointers and count = 0; in_ready = 1.
  - IR = 0; ir_valid = 0; underflow = 0.
  - All decoded outputs therefore read 0, fmt = 0.
- Push: when in_valid && in_ready at the rising edge, in_ins is written at wr_ptr; wr_ptr increments modulo DEPTH.
  - in_valid while full is ignored, with no overwrite. The producer must hold the word.
- Pop: when ir_write && count > 0 at the rising edge:
  - IR <= head entry; rd_ptr increments modulo DEPTH; ir_valid <= 1.
- Empty pop: when ir_write && count == 0:
  - IR holds its value; ir_valid <= 0; underflow <= 1 for that cycle only.
  - There is no bypass: a word pushed in the same cycle is enqueued, not loaded.
- Simultaneous push and pop with 0 < count < DEPTH: both happen, count unchanged.
- When full, push is blocked even if a pop occurs in the same cycle, because in_ready depends only on the registered count.
- Without ir_write, IR and ir_valid hold indefinitely. This is the multicycle hold.
- Flush has top priority over push and pop in the same cycle:
  - Pointers and count <= 0; IR <= 0; ir_valid <= 0; underflow <= 0.
- Decode is combinational from the IR register only, so fields change one cycle after the popping edge.
  - fmt = 0 (R) if opcode == 6'h00.
  - fmt = 2 (J) if opcode == 6'h02 or 6'h03.
  - fmt = 1 (I) otherwise.
- imm_ext:
  - Zero-extended for opcodes 6'h0C (andi), 6'h0D (ori), 6'h0E (xori).
  - Sign-extended from imm[15] for all other opcodes.
- count increments on a push-only edge, decrements on a pop-only edge, and never exceeds DEPTH or goes below 0.

Test Plan:
- Reset mid-operation: with 3 words queued and ir_valid = 1, assert rst asynchronously (between edges) -> count = 0, in_ready = 1, ir_valid = 0, opcode = 0 immediately, without waiting for a clock edge.
- Fill/full: push 0x00000001..0x00000004 (DEPTH = 4) with no pop -> count = 4, in_ready = 0. A 5th push of 0xDEADBEEF is ignored. Four pops then yield 1, 2, 3, 4 in order, after which count = 0.
- Empty pop: ir_write with count = 0 -> underflow high for exactly one cycle, ir_valid = 0, IR unchanged. A push of 0x08000010 in the same cycle leaves count = 1.
- Decode: pop 0x012A4020 -> fmt = 0, rs = 9, rt = 10, rd = 8, funct = 0x20. Pop 0x3508FFFF (ori) -> fmt = 1, imm_ext = 0x0000FFFF. Pop 0x2108FFFF (addi) -> imm_ext = 0xFFFFFFFF. Pop 0x0C000040 -> fmt = 2, jtarget = 0x40.
- Wrap-around: 10 cycles of simultaneous push/pop at count = 2 -> count stays 2, FIFO order is preserved across pointer wrap.
- Flush: flush together with push and ir_write at count = 3 -> count = 0, ir_valid = 0, IR = 0, and the pushed word is dropped.
